// File: rtl/prefetch_queue_if.sv
// ============================================================================
// Module   : prefetch_queue_if
// Summary  : Flush, bus, decoder-window and consume signals of prefetch_queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface prefetch_queue_if #(
  parameter int DATA_BYTES   = 4,
  parameter int QUEUE_BYTES  = 32,
  parameter int WINDOW_BYTES = 16,
  parameter int ADDR_WIDTH   = 32
);
  logic                                 flush_valid;
  logic [ADDR_WIDTH-1:0]                flush_address;
  logic                                 bus_vaild;
  logic                                 bus_ready;
  logic [ADDR_WIDTH-1:0]                bus_address;
  logic [DATA_BYTES*8-1:0]              bus_data;
  logic [WINDOW_BYTES*8-1:0]            window_bytes;
  logic [$clog2(WINDOW_BYTES+1)-1:0]    window_count;
  logic                                 consume_valid;
  logic [$clog2(WINDOW_BYTES+1)-1:0]    consume_count;
  logic                                 consume_error;
  logic [$clog2(QUEUE_BYTES+1)-1:0]     occupancy;

  // master: the prefetch unit itself (it masters the memory bus)
  modport master (
    input  flush_valid, flush_address, bus_ready, bus_data, consume_valid, consume_count,
    output bus_vaild, bus_address, window_bytes, window_count, consume_error, occupancy
  );

  modport slave (
    output flush_valid, flush_address, bus_ready, bus_data, consume_valid, consume_count,
    input  bus_vaild, bus_address, window_bytes, window_count, consume_error, occupancy
  );
endinterface

`default_nettype wire

// File: rtl/prefetch_queue.sv
// ============================================================================
// Module   : prefetch_queue
// Summary  : Code-byte prefetch queue: bus word fetch, byte window, flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prefetch_queue #(
  parameter int                    DATA_BYTES    = 4,
  parameter int                    QUEUE_BYTES   = 32,
  parameter int                    WINDOW_BYTES  = 16,
  parameter int                    ADDR_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDRESS = 32'hFFFF_FFF0
) (
  input  wire logic        clock,
  input  wire logic        reset,
  prefetch_queue_if.master pq
);

  localparam int QP_W  = $clog2(QUEUE_BYTES);
  localparam int OCC_W = $clog2(QUEUE_BYTES + 1);
  localparam int WC_W  = $clog2(WINDOW_BYTES + 1);
  localparam int OFF_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(DATA_BYTES - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  state_t                  r_state, w_state_next;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr_next;
  logic [ADDR_WIDTH-1:0]   r_target, w_target_next;
  logic                    r_discard, w_discard_next;
  logic [QP_W-1:0]         r_head, r_tail;
  logic [OCC_W-1:0]        r_occ;
  logic                    r_err;
  logic [7:0]              r_mem [QUEUE_BYTES];

  logic                    w_accept, w_fill, w_err;
  logic [OFF_W-1:0]        w_off;
  logic [OCC_W-1:0]        w_filled, w_cons, w_occ_next;
  logic [WC_W-1:0]         w_wcount, w_take;
  logic                    w_space_now, w_space_next;
  logic [WINDOW_BYTES*8-1:0] w_window;

  assign w_accept = (r_state == S_REQ) && pq.bus_ready;
  assign w_fill   = w_accept && !r_discard && !pq.flush_valid;
  assign w_off    = r_addr[OFF_W-1:0] & OFF_W'(DATA_BYTES - 1);
  assign w_filled = w_fill ? (OCC_W'(DATA_BYTES) - OCC_W'(w_off)) : '0;

  assign w_wcount = (r_occ > OCC_W'(WINDOW_BYTES)) ? WC_W'(WINDOW_BYTES) : WC_W'(r_occ);
  assign w_take   = (pq.consume_count > w_wcount) ? w_wcount : pq.consume_count;
  assign w_cons   = (pq.consume_valid && !pq.flush_valid) ? OCC_W'(w_take) : '0;
  assign w_err    = pq.consume_valid && (pq.consume_count > w_wcount);

  assign w_occ_next   = pq.flush_valid ? '0 : (r_occ - w_cons + w_filled);
  assign w_space_now  = (OCC_W'(QUEUE_BYTES) - r_occ) >= OCC_W'(DATA_BYTES);
  assign w_space_next = (OCC_W'(QUEUE_BYTES) - w_occ_next) >= OCC_W'(DATA_BYTES);

  // r_addr is the address of the pending (or next) request; while discarding
  // it stays frozen and r_target holds the redirect destination.
  always_comb begin
    w_state_next   = r_state;
    w_addr_next    = r_addr;
    w_target_next  = r_target;
    w_discard_next = r_discard;
    case (r_state)
      S_IDLE: begin
        if (pq.flush_valid) begin
          w_addr_next  = pq.flush_address;
          w_state_next = S_REQ;
        end else if (w_space_now) begin
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (pq.flush_valid) begin
          if (pq.bus_ready) begin
            w_addr_next    = pq.flush_address;
            w_discard_next = 1'b0;
          end else begin
            w_discard_next = 1'b1;
            w_target_next  = pq.flush_address;
          end
        end else if (pq.bus_ready) begin
          if (r_discard) begin
            w_addr_next    = r_target;
            w_discard_next = 1'b0;
          end else begin
            w_addr_next = (r_addr & ALIGN_MASK) + ADDR_WIDTH'(DATA_BYTES);
            if (!w_space_next) begin
              w_state_next = S_IDLE;
            end
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr    <= RESET_ADDRESS;
      r_target  <= RESET_ADDRESS;
      r_discard <= 1'b0;
      r_head    <= '0;
      r_tail    <= '0;
      r_occ     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_addr    <= w_addr_next;
      r_target  <= w_target_next;
      r_discard <= w_discard_next;
      r_head    <= pq.flush_valid ? '0 : (r_head + QP_W'(w_cons));
      r_tail    <= pq.flush_valid ? '0 : (r_tail + QP_W'(w_filled));
      r_occ     <= w_occ_next;
      r_err     <= w_err;
    end
  end

  // Bytes below the start offset of a misaligned beat are skipped, not stored.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (w_fill && (i >= int'(w_off))) begin
        r_mem[r_tail + QP_W'(i) - QP_W'(w_off)] <= pq.bus_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_window = '0;
    for (int k = 0; k < WINDOW_BYTES; k++) begin
      w_window[8*k +: 8] = r_mem[r_head + QP_W'(k)];
    end
  end

  assign pq.bus_vaild     = (r_state == S_REQ);
  assign pq.bus_address   = r_addr & ALIGN_MASK;
  assign pq.window_bytes  = w_window;
  assign pq.window_count  = w_wcount;
  assign pq.consume_error = r_err;
  assign pq.occupancy     = r_occ;

endmodule

`default_nettype wire
